cnn_layer_accel_weight_sequencer: RTL and testbench

CNN_LAYER_ACCEL_WEIGHT_SEQUENCER -- requirements
Module: cnn_layer_accel_weight_sequencer

---
 rtl/cnn_layer_accel_weight_seq_pkg.sv | 41 ++++
 rtl/cnn_layer_accel_gray_cnt2.sv | 31 +++
 rtl/cnn_layer_accel_weight_sequencer.sv | 154 +++++++++++++++
 tb/tb_cnn_layer_accel_weight_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_layer_accel_weight_seq_pkg.sv
// Shared definitions for the CNN layer accelerator weight sequencer.
//   - FSM state encoding (IDLE / RUN / DONE)
//   - sequence length, counter and address widths
//   - 2-bit gray-code constants and the gray advance helper
package cnn_layer_accel_weight_seq_pkg;

  localparam int unsigned SEQ_LEN = 5;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned ADDR_W  = 3;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t ADDR_LAST = addr_t'(SEQ_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] GRAY_00 = 2'b00;
  localparam logic [1:0] GRAY_01 = 2'b01;
  localparam logic [1:0] GRAY_11 = 2'b11;
  localparam logic [1:0] GRAY_10 = 2'b10;

  // Row phase order: 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] gray_next(input logic [1:0] g);
    logic [1:0] n;
    n = GRAY_00;
    unique case (g)
      GRAY_00: n = GRAY_01;
      GRAY_01: n = GRAY_11;
      GRAY_11: n = GRAY_10;
      GRAY_10: n = GRAY_00;
      default: n = GRAY_00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_gray_cnt2.sv
// Two-bit gray-code row-phase counter.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (returns to 00)
//   adv        advance one gray step this cycle
//   gray_code  current row phase
module cnn_layer_accel_gray_cnt2
  import cnn_layer_accel_weight_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  output logic [1:0] gray_code
);

  logic [1:0] gray_q;
  logic [1:0] gray_d;

  always_comb begin
    gray_d = gray_q;
    if (adv) gray_d = gray_next(gray_q);
  end

  always_ff @(posedge clk) begin
    if (rst) gray_q <= GRAY_00;
    else     gray_q <= gray_d;
  end

  assign gray_code = gray_q;

endmodule

// File: rtl/cnn_layer_accel_weight_sequencer.sv
// Weight sequencer: walks the weight sequence table for one CNN layer job.
// For each of num_rows rows and num_cols columns it emits addresses 0..4,
// toggling sequence_selector on each column wrap and advancing the gray row
// phase after each row.
// Optional feature macro: CNN_LAYER_ACCEL_WHT_SEQ_STALL_EN adds the stall input.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 job start pulse (sampled in IDLE only)
//   num_rows, num_cols    job dimensions, latched on accepted start
//   seq_valid             address triple valid (RUN)
//   gray_code             row phase to the table
//   sequence_selector     column parity select to the table
//   seq_data_addr         sequence index 0..4
//   busy                  state is not IDLE
//   done                  one-cycle job completion pulse
//   stall                 (macro only) freeze sequencing while in RUN
module cnn_layer_accel_weight_sequencer
  import cnn_layer_accel_weight_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_rows,
  input  logic [CNT_W-1:0] num_cols,
  output logic             seq_valid,
  output logic [1:0]       gray_code,
  output logic             sequence_selector,
  output logic [2:0]       seq_data_addr,
  output logic             busy,
  output logic             done
`ifdef CNN_LAYER_ACCEL_WHT_SEQ_STALL_EN
  ,
  input  logic             stall
`endif
);

  state_t state_q, state_d;
  cnt_t   rows_q, rows_d;
  cnt_t   cols_q, cols_d;
  cnt_t   row_cnt_q, row_cnt_d;
  cnt_t   col_cnt_q, col_cnt_d;
  addr_t  addr_q, addr_d;
  logic   sel_q, sel_d;
  logic   gray_adv;
  logic   gray_clr;
  logic   stall_w;

`ifdef CNN_LAYER_ACCEL_WHT_SEQ_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath next values
  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    gray_adv  = 1'b0;
    gray_clr  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rows_d = num_rows;
          cols_d = num_cols;
          if ((num_rows != '0) && (num_cols != '0)) begin
            state_d   = ST_RUN;
            row_cnt_d = '0;
            col_cnt_d = '0;
            addr_d    = '0;
            sel_d     = 1'b1;
            gray_clr  = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (!stall_w) begin
          if (addr_q == ADDR_LAST) begin
            if (col_cnt_q == (cols_q - cnt_t'(1))) begin
              // Final triple of the job leaves the outputs on their last values.
              if (row_cnt_q == (rows_q - cnt_t'(1))) begin
                state_d = ST_DONE;
              end else begin
                row_cnt_d = row_cnt_q + cnt_t'(1);
                col_cnt_d = '0;
                addr_d    = '0;
                sel_d     = 1'b1;
                gray_adv  = 1'b1;
              end
            end else begin
              col_cnt_d = col_cnt_q + cnt_t'(1);
              addr_d    = '0;
              sel_d     = ~sel_q;
            end
          end else begin
            addr_d = addr_q + addr_t'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q    <= '0;
      cols_q    <= '0;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      addr_q    <= '0;
      sel_q     <= 1'b1;
    end else begin
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
    end
  end

  // A new job always begins on phase 00, so the counter is cleared on entry to RUN.
  cnn_layer_accel_gray_cnt2 u_gray (
    .clk       (clk),
    .rst       (rst | gray_clr),
    .adv       (gray_adv),
    .gray_code (gray_code)
  );

  // Outputs
  always_comb begin
    seq_valid = (state_q == ST_RUN);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
  end

  assign sequence_selector = sel_q;
  assign seq_data_addr     = addr_q;

endmodule

// File: tb/tb_cnn_layer_accel_weight_sequencer.sv
module tb_cnn_layer_accel_weight_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] num_rows = '0;
  logic [9:0] num_cols = '0;
  logic       stall = 1'b0;
  logic       seq_valid;
  logic [1:0] gray_code;
  logic       sequence_selector;
  logic [2:0] seq_data_addr;
  logic       busy;
  logic       done;

  cnn_layer_accel_weight_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .num_rows          (num_rows),
    .num_cols          (num_cols),
    .seq_valid         (seq_valid),
    .gray_code         (gray_code),
    .sequence_selector (sequence_selector),
    .seq_data_addr     (seq_data_addr),
    .busy              (busy),
    .done              (done)
`ifdef CNN_LAYER_ACCEL_WHT_SEQ_STALL_EN
    ,
    .stall             (stall)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int done_cyc  = 0;
  int valid_cnt = 0;
  int done_cnt  = 0;
  int busy_cnt  = 0;

  logic [5:0] exp_q[$];
  logic [1:0] gtab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every presented triple against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (seq_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          logic [5:0] e;
          e = exp_q.pop_front();
          chk("triple{gray,sel,addr}", int'({gray_code, sequence_selector, seq_data_addr}), int'(e));
        end
      end
    end
  end

  task automatic push_job(input int rows, input int cols, input int maxn);
    int n;
    n = 0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        for (int a = 0; a < 5; a++) begin
          if (n < maxn) exp_q.push_back({gtab[r % 4], (c % 2 == 0), 3'(a)});
          n++;
        end
  endtask

  task automatic clear_counts();
    valid_cnt = 0;
    done_cnt  = 0;
    busy_cnt  = 0;
  endtask

  task automatic start_job(input int rows, input int cols);
    @(posedge clk); #1;
    num_rows  = 10'(rows);
    num_cols  = 10'(cols);
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk); #1;
      if (done_cnt != 0) break;
    end
    chk({name, "_done_seen"}, int'(done_cnt != 0), 1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_valid", int'(seq_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_gray", int'(gray_code), 0);
    chk("rst_sel", int'(sequence_selector), 1);
    chk("rst_addr", int'(seq_data_addr), 0);

    // rows=1 cols=2, with an ignored second start while busy
    clear_counts();
    push_job(1, 2, 1000);
    start_job(1, 2);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("j12");
    chk("j12_valid_cnt", valid_cnt, 10);
    chk("j12_done_cnt", done_cnt, 1);
    chk("j12_done_latency", done_cyc - start_cyc, 11);
    chk("j12_hold_addr", int'(seq_data_addr), 4);
    chk("j12_hold_sel", int'(sequence_selector), 0);
    chk("j12_hold_gray", int'(gray_code), 0);
    chk("j12_queue_left", exp_q.size(), 0);

    // rows=5 cols=1; dimensions changed mid-job must be ignored
    clear_counts();
    push_job(5, 1, 1000);
    start_job(5, 1);
    num_rows = 10'd0;
    num_cols = 10'd3;
    wait_done("j51");
    chk("j51_valid_cnt", valid_cnt, 25);
    chk("j51_done_cnt", done_cnt, 1);
    chk("j51_done_latency", done_cyc - start_cyc, 26);
    chk("j51_queue_left", exp_q.size(), 0);

    // rows=0 cols=7: straight to DONE
    clear_counts();
    start_job(0, 7);
    wait_done("j07");
    chk("j07_valid_cnt", valid_cnt, 0);
    chk("j07_done_latency", done_cyc - start_cyc, 1);
    chk("j07_busy_cycles", busy_cnt, 1);

    // rows=3 cols=0: also straight to DONE
    clear_counts();
    start_job(3, 0);
    wait_done("j30");
    chk("j30_valid_cnt", valid_cnt, 0);
    chk("j30_busy_cycles", busy_cnt, 1);

    // rows=2 cols=3, reset asserted during valid cycle 17
    clear_counts();
    push_job(2, 3, 17);
    start_job(2, 3);
    begin
      int k;
      for (k = 0; k < 100; k++) begin
        @(negedge clk); #1;
        if (valid_cnt >= 17) break;
      end
    end
    chk("abort_reached_17", valid_cnt, 17);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("abort_valid", int'(seq_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_gray", int'(gray_code), 0);
    chk("abort_sel", int'(sequence_selector), 1);
    chk("abort_addr", int'(seq_data_addr), 0);
    repeat (20) @(negedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_valid_cnt", valid_cnt, 17);
    chk("abort_queue_left", exp_q.size(), 0);

`ifdef CNN_LAYER_ACCEL_WHT_SEQ_STALL_EN
    // rows=1 cols=1, stall during valid cycles 3..5
    clear_counts();
    exp_q.push_back({2'b00, 1'b1, 3'd0});
    exp_q.push_back({2'b00, 1'b1, 3'd1});
    repeat (4) exp_q.push_back({2'b00, 1'b1, 3'd2});
    exp_q.push_back({2'b00, 1'b1, 3'd3});
    exp_q.push_back({2'b00, 1'b1, 3'd4});
    start_job(1, 1);
    @(posedge clk); #1;
    @(posedge clk); #1 stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    wait_done("stall11");
    chk("stall11_valid_cnt", valid_cnt, 8);
    chk("stall11_done_latency", done_cyc - start_cyc, 9);
    chk("stall11_queue_left", exp_q.size(), 0);

    // stall has no effect outside RUN
    clear_counts();
    stall = 1'b1;
    start_job(0, 4);
    wait_done("stall_idle");
    chk("stall_idle_latency", done_cyc - start_cyc, 1);
    chk("stall_idle_busy", busy_cnt, 1);
    stall = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
